// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, talks to
//   a variable-latency instruction memory through a req/ready handshake, and
//   loads the Fetch/Decode (IF/ID) register that feeds the decoder. It honours
//   Stall from the hazard unit, Flush, and taken-branch/jump/jr redirects.
//
// Ports
//   Clk, Reset         clock (rising edge), asynchronous active-high reset
//   Stall              hold IF/ID and PC
//   Flush              bubble IF/ID at the next edge
//   RedirectValid/PC   redirect fetch to RedirectPC (low two bits forced to 0)
//   IMemReq/Addr       fetch request and word-aligned address
//   IMemReady/Data     memory response; a transfer is IMemReq && IMemReady
//   PCResult           current PC
//   InstrDecode        IF/ID instruction word
//   PCAddResultDecode  IF/ID PC+4 of InstrDecode
//   ValidDecode        IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        RedirectValid,
   input  logic [31:0] RedirectPC,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemReady,
   input  logic [31:0] IMemData,
   output logic [31:0] PCResult,
   output logic [31:0] InstrDecode,
   output logic [31:0] PCAddResultDecode,
   output logic        ValidDecode
);

   // FETCH: request at PC. WAIT: request outstanding, memory not ready yet.
   // HOLD: word captured under Stall, waiting for release.
   // DROP: PC already redirected, draining the abandoned request.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_add_q, pc_add_d;
   logic        valid_q, valid_d;
   logic [31:0] buf_q, buf_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;

   logic        xfer;
   logic [31:0] pc_plus4;

   assign xfer     = req_q & IMemReady;
   assign pc_plus4 = pc_q + 32'd4;  // wraps to 0 past 32'hFFFF_FFFC

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_add_d = pc_add_q;
      valid_d  = valid_q;
      buf_d    = buf_q;

      if (RedirectValid) begin
         pc_d     = {RedirectPC[31:2], 2'b00};
         instr_d  = NOP_INSTR;
         pc_add_d = 32'd0;
         valid_d  = 1'b0;
         buf_d    = 32'd0;
         // A request still waiting on the memory must be drained at its own
         // address; the address may not move while the request is pending.
         if ((state_q != S_HOLD) && !xfer) state_d = S_DROP;
         else                              state_d = S_FETCH;
      end else begin
         unique case (state_q)
            S_FETCH, S_WAIT: begin
               if (xfer) begin
                  if (Stall && !Flush) begin
                     buf_d   = IMemData;
                     state_d = S_HOLD;
                  end else begin
                     instr_d  = IMemData;
                     pc_add_d = pc_plus4;
                     valid_d  = 1'b1;
                     pc_d     = pc_plus4;
                     state_d  = S_FETCH;
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_HOLD: begin
               // Flush behaves as a stall release for PC and FSM.
               if (!Stall || Flush) begin
                  instr_d  = buf_q;
                  pc_add_d = pc_plus4;
                  valid_d  = 1'b1;
                  pc_d     = pc_plus4;
                  state_d  = S_FETCH;
               end
            end
            S_DROP: begin
               if (xfer) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase

         // Flush overrides whatever would have been loaded into IF/ID.
         if (Flush) begin
            instr_d  = NOP_INSTR;
            pc_add_d = 32'd0;
            valid_d  = 1'b0;
         end
      end

      req_d  = (state_d != S_HOLD);
      addr_d = (state_d == S_DROP) ? addr_q : pc_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc_add_q <= 32'd0;
         valid_q  <= 1'b0;
         // NOTE: the hold buffer is a single register, so it is cleared on
         // reset like any other state; only true memory arrays skip reset.
         buf_q    <= 32'd0;
         req_q    <= 1'b1;
         addr_q   <= RESET_PC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_add_q <= pc_add_d;
         valid_q  <= valid_d;
         buf_q    <= buf_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
      end
   end

   assign IMemReq           = req_q;
   assign IMemAddr          = addr_q;
   assign PCResult          = pc_q;
   assign InstrDecode       = instr_q;
   assign PCAddResultDecode = pc_add_q;
   assign ValidDecode       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A reference model tracks the PC, the
//   IF/ID contents, a queue holding a word captured under Stall, and a queue
//   holding the address of an abandoned fetch. Memory word at address A is A>>2.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Stall;
   logic        Flush;
   logic        RedirectValid;
   logic [31:0] RedirectPC;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemReady;
   logic [31:0] IMemData;
   logic [31:0] PCResult;
   logic [31:0] InstrDecode;
   logic [31:0] PCAddResultDecode;
   logic        ValidDecode;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .Stall             (Stall),
      .Flush             (Flush),
      .RedirectValid     (RedirectValid),
      .RedirectPC        (RedirectPC),
      .IMemReq           (IMemReq),
      .IMemAddr          (IMemAddr),
      .IMemReady         (IMemReady),
      .IMemData          (IMemData),
      .PCResult          (PCResult),
      .InstrDecode       (InstrDecode),
      .PCAddResultDecode (PCAddResultDecode),
      .ValidDecode       (ValidDecode)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   logic [31:0] m_pc, m_instr, m_pcadd;
   logic        m_valid;
   logic [31:0] m_buf[$];   // word captured under Stall (at most one)
   logic [31:0] m_drop[$];  // address of an abandoned fetch (at most one)

   function automatic logic m_req();
      return (m_buf.size() == 0);
   endfunction

   function automatic logic [31:0] m_addr();
      return (m_drop.size() != 0) ? m_drop[0] : m_pc;
   endfunction

   task automatic m_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pcadd = 32'h0; m_valid = 1'b0;
      m_buf.delete(); m_drop.delete();
   endtask

   task automatic m_bubble();
      m_instr = 32'h0; m_pcadd = 32'h0; m_valid = 1'b0;
   endtask

   // One clock edge of the model, using the inputs presented before the edge.
   task automatic m_step();
      logic        req, xfer, has_word;
      logic [31:0] word;
      req  = m_req();
      xfer = req && IMemReady;
      if (RedirectValid) begin
         if (m_drop.size() != 0) begin
            if (xfer) m_drop.delete();
         end else if (req && !xfer) begin
            m_drop.push_back(m_pc);
         end
         m_buf.delete();
         m_pc = {RedirectPC[31:2], 2'b00};
         m_bubble();
      end else if (m_drop.size() != 0) begin
         if (xfer) m_drop.delete();
         if (Flush) m_bubble();
      end else begin
         has_word = (m_buf.size() != 0) || xfer;
         word     = (m_buf.size() != 0) ? m_buf[0] : IMemData;
         if (has_word) begin
            if (Stall && !Flush) begin
               if (m_buf.size() == 0) m_buf.push_back(IMemData);
            end else begin
               m_buf.delete();
               m_instr = word; m_pcadd = m_pc + 32'd4; m_valid = 1'b1;
               m_pc    = m_pc + 32'd4;
            end
         end
         if (Flush) m_bubble();
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("pc",    PCResult,           m_pc);
      check("instr", InstrDecode,        m_instr);
      check("valid", {31'd0, ValidDecode}, {31'd0, m_valid});
      if (m_valid) check("pcadd", PCAddResultDecode, m_pcadd);
      check("req",   {31'd0, IMemReq},   {31'd0, m_req()});
      if (m_req()) check("addr", IMemAddr, m_addr());
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pc"},    PCResult,             32'h0);
      check({tag, "_instr"}, InstrDecode,          32'h0);
      check({tag, "_pcadd"}, PCAddResultDecode,    32'h0);
      check({tag, "_valid"}, {31'd0, ValidDecode}, 32'd0);
   endtask

   // Drive inputs at the falling edge, advance one rising edge, compare at the
   // next falling edge.
   task automatic cycle(input logic s, input logic f, input logic r,
                        input logic [31:0] rp, input logic rdy);
      Stall = s; Flush = f; RedirectValid = r; RedirectPC = rp; IMemReady = rdy;
      IMemData = rdy ? (m_addr() >> 2) : $urandom();
      @(posedge Clk);
      m_step();
      @(negedge Clk);
      compare_all();
   endtask

   initial begin
      Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; RedirectValid = 1'b0;
      RedirectPC = 32'h0; IMemReady = 1'b0; IMemData = 32'h0;
      m_reset();
      repeat (2) @(negedge Clk);
      check_reset_vals("rst");
      Reset = 1'b0;
      #1;
      check("rst_req",  {31'd0, IMemReq}, 32'd1);
      check("rst_addr", IMemAddr,         32'h0);
      @(negedge Clk);
      compare_all();

      // Zero-wait stream.
      cycle(0, 0, 0, 0, 1);
      check("t1_pc4",   PCResult,    32'd4);
      check("t1_i0",    InstrDecode, 32'd0);
      check("t1_valid", {31'd0, ValidDecode}, 32'd1);
      cycle(0, 0, 0, 0, 1);
      check("t1_pc8",   PCResult,    32'd8);
      check("t1_i1",    InstrDecode, 32'd1);

      // Memory not ready for three cycles at PC=8.
      repeat (3) begin
         cycle(0, 0, 0, 0, 0);
         check("t2_addr", IMemAddr,    32'd8);
         check("t2_req",  {31'd0, IMemReq}, 32'd1);
         check("t2_hold", InstrDecode, 32'd1);
      end
      cycle(0, 0, 0, 0, 1);
      check("t2_i2", InstrDecode, 32'd2);

      // Stall coinciding with the transfer at PC=12.
      cycle(1, 0, 0, 0, 1);
      check("t3_req", {31'd0, IMemReq}, 32'd0);
      check("t3_pc",  PCResult,         32'd12);
      cycle(1, 0, 0, 0, 1);
      check("t3_pc2", PCResult,         32'd12);
      cycle(0, 0, 0, 0, 1);
      check("t3_i3",    InstrDecode,       32'd3);
      check("t3_pcadd", PCAddResultDecode, 32'd16);

      // Redirect during WAIT at PC=20.
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 32'h43, 0);
      check("t4_pc",    PCResult,             32'h40);
      check("t4_valid", {31'd0, ValidDecode}, 32'd0);
      check("t4_drop",  IMemAddr,             32'd20);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      check("t4_addr",  IMemAddr,             32'h40);
      check("t4_valid2", {31'd0, ValidDecode}, 32'd0);
      cycle(0, 0, 0, 0, 1);
      check("t4_i", InstrDecode, 32'h10);

      // Stall+Flush, then Redirect+Stall.
      cycle(1, 1, 0, 0, 0);
      check("t5_valid", {31'd0, ValidDecode}, 32'd0);
      check("t5_instr", InstrDecode,          32'h0);
      check("t5_pc",    PCResult,             32'h44);
      cycle(1, 0, 1, 32'h100, 1);
      check("t5_redir", PCResult, 32'h100);

      // Wrap past the top of the address space.
      cycle(0, 0, 1, 32'hFFFF_FFFC, 1);
      check("t6_top", PCResult, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0, 1);
      check("t6_wrap",  PCResult,    32'h0);
      check("t6_instr", InstrDecode, 32'h3FFF_FFFF);

      // Asynchronous reset in the middle of a WAIT.
      cycle(0, 0, 0, 0, 0);
      #2 Reset = 1'b1;
      #1 check_reset_vals("arst");
      check("arst_req", {31'd0, IMemReq}, 32'd1);
      m_reset();
      @(negedge Clk);
      Reset = 1'b0;
      #1 compare_all();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic        s, f, r, rdy;
         logic [31:0] rp;
         s   = ($urandom_range(0, 99) < 20);
         f   = ($urandom_range(0, 99) < 6);
         r   = ($urandom_range(0, 99) < 6);
         rdy = ($urandom_range(0, 99) < 70);
         rp  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom();
         cycle(s, f, r, rp, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
